// File: rtl/ngy_sram_arbiter_if.sv
// Request/acknowledge bundle between the two SRAM requesters and the arbiter.
// Port A is the read-only video scanout port; port B is the read/write game-logic port.
interface ngy_sram_arbiter_if;
  logic        a_req;
  logic [16:0] a_addr;
  logic        a_ack;
  logic [15:0] a_rdata;

  logic        b_req;
  logic        b_we;
  logic [16:0] b_addr;
  logic [15:0] b_wdata;
  logic [1:0]  b_be;
  logic        b_ack;
  logic [15:0] b_rdata;

  logic        busy;

  modport slave (
    input  a_req, a_addr, b_req, b_we, b_addr, b_wdata, b_be,
    output a_ack, a_rdata, b_ack, b_rdata, busy
  );

  modport master (
    output a_req, a_addr, b_req, b_we, b_addr, b_wdata, b_be,
    input  a_ack, a_rdata, b_ack, b_rdata, busy
  );
endinterface

// File: rtl/ngy_sram_arbiter.sv
// Two-port arbiter for an asynchronous 16-bit SRAM: round-robin on ties, one transfer
// of WAIT_CYCLES access cycles followed by a bus-turnaround cycle that carries the ack.
module ngy_sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                clk_74a,
  input  logic                reset,
  ngy_sram_arbiter_if.slave   bus,
  output logic [16:0]         sram_a,
  inout  wire  [15:0]         sram_dq,
  output logic                sram_oe_n,
  output logic                sram_we_n,
  output logic                sram_ub_n,
  output logic                sram_lb_n
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_b_q, last_b_d;
  logic        gnt_b_q, gnt_b_d;
  logic        we_q, we_d;
  logic [16:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] a_rdata_q, a_rdata_d;
  logic [15:0] b_rdata_q, b_rdata_d;
  logic        a_ack_q, a_ack_d;
  logic        b_ack_q, b_ack_d;
  logic        grant_b;
  logic        access;

  // B wins only when A is idle or A was the last port served.
  assign grant_b = bus.b_req && (!bus.a_req || !last_b_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_b_d  = last_b_q;
    gnt_b_d   = gnt_b_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.a_req || bus.b_req) begin
          state_d  = ACCESS;
          cnt_d    = 4'd0;
          gnt_b_d  = grant_b;
          last_b_d = grant_b;
          if (grant_b) begin
            we_d    = bus.b_we;
            addr_d  = bus.b_addr;
            wdata_d = bus.b_wdata;
            // Reads always enable both lanes regardless of the requested byte enables.
            be_d    = bus.b_we ? bus.b_be : 2'b11;
          end else begin
            we_d   = 1'b0;
            addr_d = bus.a_addr;
            be_d   = 2'b11;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          a_ack_d = !gnt_b_q;
          b_ack_d = gnt_b_q;
          if (!we_q) begin
            if (gnt_b_q) b_rdata_d = sram_dq;
            else         a_rdata_d = sram_dq;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_74a) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      last_b_q  <= 1'b1;
      gnt_b_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 17'd0;
      wdata_q   <= 16'd0;
      be_q      <= 2'b00;
      a_rdata_q <= 16'd0;
      b_rdata_q <= 16'd0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_b_q  <= last_b_d;
      gnt_b_q   <= gnt_b_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
    end
  end

  assign access = (state_q == ACCESS);

  // The first write cycle is address setup, so the write strobe starts on the second.
  assign sram_a    = addr_q;
  assign sram_oe_n = !(access && !we_q);
  assign sram_we_n = !(access && we_q && (cnt_q != 4'd0) && (be_q != 2'b00));
  assign sram_ub_n = !(access && be_q[1]);
  assign sram_lb_n = !(access && be_q[0]);
  assign sram_dq   = (access && we_q) ? wdata_q : 16'hzzzz;

  assign bus.a_ack   = a_ack_q;
  assign bus.b_ack   = b_ack_q;
  assign bus.a_rdata = a_rdata_q;
  assign bus.b_rdata = b_rdata_q;
  assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_ngy_sram_arbiter.sv
// Bench for ngy_sram_arbiter: directed transfer table, tie/abort sequences, a randomized
// run against a transaction-level model, and a WAIT_CYCLES=4 instance.
module tb_ngy_sram_arbiter;
  localparam int W1    = 2;
  localparam int W2    = 4;
  localparam int NRAND = 400;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ngy_sram_arbiter_if bus1 ();
  ngy_sram_arbiter_if bus2 ();

  logic [16:0] sram_a1, sram_a2;
  wire  [15:0] dq1, dq2;
  logic oe1_n, we1_n, ub1_n, lb1_n;
  logic oe2_n, we2_n, ub2_n, lb2_n;

  ngy_sram_arbiter #(.WAIT_CYCLES(W1)) dut (
    .clk_74a(clk), .reset(reset), .bus(bus1),
    .sram_a(sram_a1), .sram_dq(dq1),
    .sram_oe_n(oe1_n), .sram_we_n(we1_n), .sram_ub_n(ub1_n), .sram_lb_n(lb1_n)
  );

  ngy_sram_arbiter #(.WAIT_CYCLES(W2)) dut4 (
    .clk_74a(clk), .reset(reset), .bus(bus2),
    .sram_a(sram_a2), .sram_dq(dq2),
    .sram_oe_n(oe2_n), .sram_we_n(we2_n), .sram_ub_n(ub2_n), .sram_lb_n(lb2_n)
  );

  // Simple SRAM models, reloaded with known contents whenever reset is held.
  logic [15:0] mem1 [0:131071];
  logic [15:0] mem2 [0:15];

  function automatic logic [15:0] initval(input logic [16:0] a);
    return (a == 17'h00010) ? 16'hBEEF : (a[15:0] ^ 16'hA5A5);
  endfunction

  assign dq1 = (!oe1_n && we1_n) ? mem1[sram_a1] : 16'hzzzz;
  assign dq2 = (!oe2_n && we2_n) ? mem2[sram_a2[3:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 131072; i++) mem1[i] <= initval(17'(i));
      for (int i = 0; i < 16; i++) mem2[i] <= 16'h1000 + 16'(i);
    end else begin
      if (!we1_n && !ub1_n) mem1[sram_a1][15:8] <= dq1[15:8];
      if (!we1_n && !lb1_n) mem1[sram_a1][7:0]  <= dq1[7:0];
      if (!we2_n && !ub2_n) mem2[sram_a2[3:0]][15:8] <= dq2[15:8];
      if (!we2_n && !lb2_n) mem2[sram_a2[3:0]][7:0]  <= dq2[7:0];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus1.a_req = 0; bus1.a_addr = '0; bus1.b_req = 0; bus1.b_we = 0;
    bus1.b_addr = '0; bus1.b_wdata = '0; bus1.b_be = '0;
    bus2.a_req = 0; bus2.a_addr = '0; bus2.b_req = 0; bus2.b_we = 0;
    bus2.b_addr = '0; bus2.b_wdata = '0; bus2.b_be = '0;
  endtask

  // Leaves the bench just after a rising edge, with reset low: that cycle is cycle 0.
  task automatic do_reset();
    reset = 1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
  endtask

  typedef struct {
    bit          port_b;
    bit          we;
    logic [16:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    int          ack_c;
    logic [15:0] rd;
    logic [15:0] mem;
    int          oe_lo;
    int          oe_first;
    int          we_lo;
    int          we_first;
    bit          ub;
    bit          lb;
  } vec_t;

  typedef struct {
    int          ack_c;
    logic [15:0] rd;
    int          oe_lo;
    int          oe_first;
    int          we_lo;
    int          we_first;
    bit          ub;
    bit          lb;
    int          stray;
    logic        ack_after;
    logic        busy_after;
    logic [16:0] a_idle;
  } obs_t;

  // One transfer on the WAIT_CYCLES=2 instance; inputs are scrambled once the grant is taken.
  task automatic xfer1(input vec_t v, output obs_t o);
    o = '{ack_c: -1, rd: '0, oe_lo: 0, oe_first: -1, we_lo: 0, we_first: -1,
          ub: 0, lb: 0, stray: 0, ack_after: 0, busy_after: 0, a_idle: '0};
    if (v.port_b) begin
      bus1.b_req = 1; bus1.b_we = v.we; bus1.b_addr = v.addr;
      bus1.b_wdata = v.wdata; bus1.b_be = v.be;
    end else begin
      bus1.a_req = 1; bus1.a_addr = v.addr;
    end
    for (int c = 0; c < 20; c++) begin
      if (c == 1) begin
        bus1.a_addr = ~bus1.a_addr; bus1.b_addr = ~bus1.b_addr;
        bus1.b_wdata = ~bus1.b_wdata; bus1.b_be = ~bus1.b_be; bus1.b_we = ~bus1.b_we;
      end
      @(negedge clk);
      if (!oe1_n) begin o.oe_lo++; if (o.oe_first < 0) o.oe_first = c; end
      if (!we1_n) begin o.we_lo++; if (o.we_first < 0) o.we_first = c; end
      if (!ub1_n) o.ub = 1;
      if (!lb1_n) o.lb = 1;
      if (v.port_b ? bus1.a_ack : bus1.b_ack) o.stray++;
      if (v.port_b ? bus1.b_ack : bus1.a_ack) begin
        o.ack_c = c;
        o.rd = v.port_b ? bus1.b_rdata : bus1.a_rdata;
        break;
      end
      @(posedge clk); #1;
    end
    bus1.a_req = 0; bus1.b_req = 0;
    @(posedge clk); #1;
    @(negedge clk);
    o.ack_after  = bus1.a_ack | bus1.b_ack;
    o.busy_after = bus1.busy;
    o.a_idle     = sram_a1;
    @(posedge clk); #1;
  endtask

  task automatic run2(input bit pb, input bit we, input logic [16:0] addr, input logic [15:0] wd,
                      input logic [1:0] be, output int ackc, output logic [15:0] rd);
    ackc = -1; rd = '0;
    if (pb) begin
      bus2.b_req = 1; bus2.b_we = we; bus2.b_addr = addr; bus2.b_wdata = wd; bus2.b_be = be;
    end else begin
      bus2.a_req = 1; bus2.a_addr = addr;
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (pb ? bus2.b_ack : bus2.a_ack) begin
        ackc = c;
        rd = pb ? bus2.b_rdata : bus2.a_rdata;
        break;
      end
      @(posedge clk); #1;
    end
    bus2.a_req = 0; bus2.b_req = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  // Transaction-level reference state for the randomized run.
  logic [15:0] ref_mem [int];
  logic [16:0] pool [5] = '{17'h00010, 17'h00011, 17'h1FFFF, 17'h00002, 17'h00003};
  logic        a_act, b_act, rb_we;
  logic [16:0] ra_addr, rb_addr;
  logic [15:0] rb_wdata;
  logic [1:0]  rb_be;

  function automatic logic [15:0] ref_rd(input logic [16:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : initval(a);
  endfunction

  task automatic new_a();
    ra_addr = pool[$urandom_range(4, 0)];
  endtask

  task automatic new_b();
    rb_we = 1'($urandom_range(1, 0)); rb_addr = pool[$urandom_range(4, 0)];
    rb_wdata = 16'($urandom); rb_be = 2'($urandom_range(3, 0));
  endtask

  task automatic drive_rand();
    bus1.a_req = a_act; bus1.a_addr = ra_addr;
    bus1.b_req = b_act; bus1.b_we = rb_we; bus1.b_addr = rb_addr;
    bus1.b_wdata = rb_wdata; bus1.b_be = rb_be;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [7];
    obs_t        o;
    int          qa[$], qb[$];
    logic [15:0] ra[$], rb[$];
    int          m_free, m_g, m_ack, nack, ackc;
    bit          m_b, m_last_b, m_we, exp_a, exp_b, exp_busy;
    logic [16:0] m_addr;
    logic [15:0] m_wdata, m_ard, m_brd, w, rd;
    logic [1:0]  m_be;

    //        portB we  addr       wdata     be     ack rd        mem       oe first we first ub lb
    vecs[0] = '{1'b0, 1'b0, 17'h00010, 16'h0000, 2'b11, 3, 16'hBEEF, 16'hBEEF, 2, 1, 0, -1, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 17'h1FFFF, 16'h1234, 2'b10, 3, 16'h0000, 16'h125A, 0, -1, 1, 2, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 17'h00020, 16'hCAFE, 2'b00, 3, 16'h0000, 16'hA585, 0, -1, 0, -1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 17'h1FFFF, 16'h0000, 2'b00, 3, 16'h125A, 16'h125A, 2, 1, 0, -1, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 17'h00010, 16'h5555, 2'b11, 3, 16'h125A, 16'h5555, 0, -1, 1, 2, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 17'h00010, 16'h0000, 2'b11, 3, 16'h5555, 16'h5555, 2, 1, 0, -1, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 17'h00030, 16'hABCD, 2'b01, 3, 16'h125A, 16'hA5CD, 0, -1, 1, 2, 1'b0, 1'b1};

    do_reset();
    @(negedge clk);
    chk("reset a_ack", bus1.a_ack, 0);
    chk("reset b_ack", bus1.b_ack, 0);
    chk("reset busy", bus1.busy, 0);
    chk("reset a_rdata", bus1.a_rdata, 0);
    chk("reset b_rdata", bus1.b_rdata, 0);
    chk("reset sram_a", sram_a1, 0);
    chk("reset strobes", {oe1_n, we1_n, ub1_n, lb1_n}, 4'hF);
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      xfer1(vecs[i], o);
      $display("vec %0d: port=%s we=%0d addr=%05h ack_cycle=%0d rdata=%04h mem=%04h",
               i, vecs[i].port_b ? "B" : "A", vecs[i].we, vecs[i].addr, o.ack_c, o.rd,
               mem1[vecs[i].addr]);
      chk($sformatf("v%0d ack_cycle", i), o.ack_c, vecs[i].ack_c);
      chk($sformatf("v%0d rdata", i), o.rd, vecs[i].rd);
      chk($sformatf("v%0d mem", i), mem1[vecs[i].addr], vecs[i].mem);
      chk($sformatf("v%0d oe_low_cycles", i), o.oe_lo, vecs[i].oe_lo);
      chk($sformatf("v%0d oe_first", i), o.oe_first, vecs[i].oe_first);
      chk($sformatf("v%0d we_low_cycles", i), o.we_lo, vecs[i].we_lo);
      chk($sformatf("v%0d we_first", i), o.we_first, vecs[i].we_first);
      chk($sformatf("v%0d ub_low", i), o.ub, vecs[i].ub);
      chk($sformatf("v%0d lb_low", i), o.lb, vecs[i].lb);
      chk($sformatf("v%0d stray_ack", i), o.stray, 0);
      chk($sformatf("v%0d ack_after", i), o.ack_after, 0);
      chk($sformatf("v%0d busy_after", i), o.busy_after, 0);
      chk($sformatf("v%0d sram_a_hold", i), o.a_idle, vecs[i].addr);
    end

    // Both ports requesting continuously from reset release.
    do_reset();
    bus1.a_req = 1; bus1.a_addr = 17'h00011;
    bus1.b_req = 1; bus1.b_we = 0; bus1.b_addr = 17'h00012;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (bus1.a_ack) begin qa.push_back(c); ra.push_back(bus1.a_rdata); end
      if (bus1.b_ack) begin qb.push_back(c); rb.push_back(bus1.b_rdata); end
      @(posedge clk); #1;
    end
    idle_inputs();
    $display("tie: a_acks=%p b_acks=%p", qa, qb);
    chk("tie a_ack_count", qa.size(), 2);
    chk("tie b_ack_count", qb.size(), 2);
    chk("tie a_ack0", (qa.size() > 0) ? qa[0] : -1, 3);
    chk("tie b_ack0", (qb.size() > 0) ? qb[0] : -1, 7);
    chk("tie a_ack1", (qa.size() > 1) ? qa[1] : -1, 11);
    chk("tie b_ack1", (qb.size() > 1) ? qb[1] : -1, 15);
    chk("tie a_rdata", (ra.size() > 0) ? ra[0] : 16'h0, initval(17'h00011));
    chk("tie b_rdata", (rb.size() > 0) ? rb[0] : 16'h0, initval(17'h00012));

    // Reset during the second access cycle of a B write.
    do_reset();
    bus1.b_req = 1; bus1.b_we = 1; bus1.b_addr = 17'h00005;
    bus1.b_wdata = 16'h9999; bus1.b_be = 2'b11;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort we_low_before", we1_n, 0);
    #1;
    reset = 1; bus1.b_req = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort b_ack", bus1.b_ack, 0);
    chk("abort busy", bus1.busy, 0);
    chk("abort strobes", {oe1_n, we1_n, ub1_n, lb1_n}, 4'hF);
    chk("abort sram_a", sram_a1, 0);
    @(posedge clk); #1;
    reset = 0;
    nack = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus1.a_ack || bus1.b_ack) nack++;
      @(posedge clk); #1;
    end
    $display("abort: acks after reset=%0d b_rdata=%04h", nack, bus1.b_rdata);
    chk("abort acks_after", nack, 0);
    chk("abort b_rdata", bus1.b_rdata, 0);

    // Randomized traffic against the transaction-level model.
    do_reset();
    ref_mem.delete();
    m_free = 0; m_g = -1; m_ack = -1; m_b = 0; m_last_b = 1;
    m_we = 0; m_addr = '0; m_wdata = '0; m_be = '0; m_ard = '0; m_brd = '0;
    a_act = 1; b_act = 1; new_a(); new_b();
    drive_rand();
    for (int k = 0; k < NRAND; k++) begin
      @(negedge clk);
      exp_a    = (k == m_ack) && !m_b;
      exp_b    = (k == m_ack) && m_b;
      exp_busy = (k > m_g) && (k <= m_ack);
      if (k == m_ack) begin
        if (m_we) begin
          w = ref_rd(m_addr);
          if (m_be[1]) w[15:8] = m_wdata[15:8];
          if (m_be[0]) w[7:0]  = m_wdata[7:0];
          ref_mem[int'(m_addr)] = w;
        end else if (m_b) begin
          m_brd = ref_rd(m_addr);
        end else begin
          m_ard = ref_rd(m_addr);
        end
        $display("rand cycle %0d: port=%s we=%0d addr=%05h be=%b wdata=%04h rdata=%04h",
                 k, m_b ? "B" : "A", m_we, m_addr, m_be, m_wdata, m_b ? m_brd : m_ard);
      end
      chk($sformatf("rand c%0d a_ack", k), bus1.a_ack, exp_a);
      chk($sformatf("rand c%0d b_ack", k), bus1.b_ack, exp_b);
      chk($sformatf("rand c%0d busy", k), bus1.busy, exp_busy);
      chk($sformatf("rand c%0d a_rdata", k), bus1.a_rdata, m_ard);
      chk($sformatf("rand c%0d b_rdata", k), bus1.b_rdata, m_brd);
      if (k >= m_free && (a_act || b_act)) begin
        m_b = b_act && (!a_act || !m_last_b);
        m_last_b = m_b;
        m_g = k; m_ack = k + W1 + 1; m_free = k + W1 + 2;
        if (m_b) begin
          m_we = rb_we; m_addr = rb_addr; m_wdata = rb_wdata; m_be = rb_be;
        end else begin
          m_we = 0; m_addr = ra_addr; m_be = 2'b11;
        end
      end
      if (exp_a) begin
        a_act = 1'($urandom_range(1, 0)); if (a_act) new_a();
      end else if (!a_act && $urandom_range(3, 0) == 0) begin
        a_act = 1; new_a();
      end
      if (exp_b) begin
        b_act = 1'($urandom_range(1, 0)); if (b_act) new_b();
      end else if (!b_act && $urandom_range(3, 0) == 0) begin
        b_act = 1; new_b();
      end
      @(posedge clk); #1;
      drive_rand();
    end
    idle_inputs();
    repeat (W1 + 3) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++)
      chk($sformatf("rand mem %05h", pool[i]), mem1[pool[i]], ref_rd(pool[i]));

    // WAIT_CYCLES=4 instance.
    do_reset();
    run2(0, 0, 17'h00004, 16'h0, 2'b00, ackc, rd);
    $display("w4 A read: ack_cycle=%0d rdata=%04h", ackc, rd);
    chk("w4 a_ack_cycle", ackc, 5);
    chk("w4 a_rdata", rd, 16'h1004);
    run2(1, 1, 17'h00004, 16'h7777, 2'b11, ackc, rd);
    $display("w4 B write: ack_cycle=%0d mem=%04h", ackc, mem2[4]);
    chk("w4 b_ack_cycle", ackc, 5);
    chk("w4 a_rdata_held", bus2.a_rdata, 16'h1004);
    chk("w4 mem", mem2[4], 16'h7777);
    run2(0, 0, 17'h00004, 16'h0, 2'b00, ackc, rd);
    $display("w4 A reread: ack_cycle=%0d rdata=%04h", ackc, rd);
    chk("w4 reread", rd, 16'h7777);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ngy_sram_arbiter.md
NGY_SRAM_ARBITER -- requirements
Module: ngy_sram_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, SHALL set the SRAM access cycles per transfer; legal range 2..15.
REQ-002 clk_74a  in  1  sole clock; all state SHALL change on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 a_req  in  1  port A (video scanout) request, held until a_ack.
REQ-005 a_addr  in  17  port A word address.
REQ-006 a_ack  out  1  one-cycle completion pulse, port A.
REQ-007 a_rdata  out  16  port A read data, valid with a_ack.
REQ-008 b_req  in  1  port B (game logic) request, held until b_ack.
REQ-009 b_we  in  1  port B write (1) or read (0).
REQ-010 b_addr  in  17  port B word address.
REQ-011 b_wdata  in  16  port B write data.
REQ-012 b_be  in  2  port B byte enables: [1] upper, [0] lower.
REQ-013 b_ack  out  1  one-cycle completion pulse, port B.
REQ-014 b_rdata  out  16  port B read data, valid with b_ack.
REQ-015 busy  out  1  high whenever state is not IDLE.
REQ-016 sram_a  out  17; sram_dq  inout  16; sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each: asynchronous SRAM pins.

Function
REQ-017 States SHALL be IDLE, ACCESS, DONE; IDLE->ACCESS on any sampled request; ACCESS->DONE after exactly WAIT_CYCLES cycles; DONE->IDLE unconditionally.
REQ-018 In IDLE with one request, that port SHALL be granted; with both requesting, the port not granted last SHALL win; after reset, "last granted" SHALL be B, so A wins the first tie.
REQ-019 Port A SHALL always read with both byte lanes enabled.
REQ-020 On grant, address, direction, write data and byte enables SHALL be registered; later input changes SHALL not affect the transfer.
REQ-021 Latency: request sampled in IDLE at cycle N -> ack high in cycle N+WAIT_CYCLES+1, for exactly one cycle, only on the granted port.
REQ-022 Read: sram_oe_n=0, sram_ub_n=sram_lb_n=0 for all ACCESS cycles; sram_dq SHALL be captured on the final ACCESS edge into the granted port's rdata.
REQ-023 Each rdata SHALL hold its value until that port's next read completes; writes SHALL not alter rdata.
REQ-024 Write: sram_dq driven with registered data during all ACCESS cycles; sram_we_n=0 during ACCESS cycles 2..WAIT_CYCLES (first cycle is address setup); sram_ub_n=~be[1], sram_lb_n=~be[0] during ACCESS.
REQ-025 Write with b_be=00 SHALL complete with normal latency and ack but never assert sram_we_n, sram_ub_n or sram_lb_n.
REQ-026 sram_dq SHALL be high-impedance in IDLE, DONE, and all read ACCESS cycles; DONE is the bus turnaround cycle.
REQ-027 In IDLE and DONE, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n SHALL be 1; sram_a SHALL hold the last transfer address.
REQ-028 A requester may keep req high in the cycle after ack to issue a new transfer; it is sampled in the following IDLE cycle (throughput one transfer per WAIT_CYCLES+2 cycles).
REQ-029 Requests arriving during ACCESS or DONE SHALL wait; no request SHALL be dropped or acked twice.

Reset
REQ-030 Reset SHALL force, at the next edge: state IDLE, a_ack=b_ack=0, busy=0, a_rdata=b_rdata=0, sram_a=0, all SRAM strobes 1, sram_dq high-impedance, last-granted=B.
REQ-031 Reset during ACCESS or DONE SHALL abort the transfer with no ack; that request is reissued by its holder after reset.

Verification
REQ-032 Single A read, WAIT_CYCLES=2, SRAM model word 0x00010=0xBEEF: a_req at cycle 0 -> a_ack at cycle 3, a_rdata=0xBEEF, sram_oe_n low in cycles 1-2 only.
REQ-033 B write addr 0x1FFFF data 0x1234 be=10: sram_we_n low in cycle 2 only, sram_ub_n=0, sram_lb_n=1; model upper byte=0x12, lower byte unchanged; b_ack at cycle 3.
REQ-034 a_req and b_req both high continuously from reset release: grants alternate A,B,A,B; acks at cycles 3,7,11,15.
REQ-035 B write be=00: b_ack at cycle 3; sram_we_n, sram_ub_n, sram_lb_n stay 1 throughout; model memory unchanged.
REQ-036 Reset asserted in second ACCESS cycle of a B write: no b_ack, sram_we_n=1 and sram_dq high-impedance the next cycle, busy=0.
REQ-037 WAIT_CYCLES=4, A read: a_ack at cycle 5; a_rdata unchanged by an intervening B write.
